// File: rtl/multiseg_capture.sv
// Display sniffer for a 4-digit multiplexed 7-segment bus: filters scan
// transitions, decodes each digit to BCD and publishes coherent frames.
module multiseg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  seg_anode,
    input  logic [6:0]  seg_cathode,
    output logic [15:0] bcd_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        frame_done
);

    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_HIT = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_HIT  = TW'(TIMEOUT_CYCLES - 1);

    // {valid, digit}
    function automatic logic [4:0] seg_decode(input logic [6:0] cath);
        case (cath)
            7'h40:   seg_decode = {1'b1, 4'd0};
            7'h79:   seg_decode = {1'b1, 4'd1};
            7'h24:   seg_decode = {1'b1, 4'd2};
            7'h30:   seg_decode = {1'b1, 4'd3};
            7'h19:   seg_decode = {1'b1, 4'd4};
            7'h12:   seg_decode = {1'b1, 4'd5};
            7'h02:   seg_decode = {1'b1, 4'd6};
            7'h78:   seg_decode = {1'b1, 4'd7};
            7'h00:   seg_decode = {1'b1, 4'd8};
            7'h10:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    // {one_hot_low, digit_index}
    function automatic logic [2:0] anode_sel(input logic [3:0] an);
        case (an)
            4'b1110: anode_sel = 3'b100;
            4'b1101: anode_sel = 3'b101;
            4'b1011: anode_sel = 3'b110;
            4'b0111: anode_sel = 3'b111;
            default: anode_sel = 3'b000;
        endcase
    endfunction

    logic [10:0]   samp_q, samp_d;
    logic [10:0]   prev_q, prev_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    sherr_q, sherr_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    err_q, err_d;
    logic          fv_q, fv_d;
    logic          fd_q, fd_d;

    logic [2:0]    sel;
    logic [4:0]    dec;
    logic          cap;

    always_comb begin
        samp_d = {seg_anode, seg_cathode};
        prev_d = samp_q;

        if (samp_q != prev_q)
            stab_d = '0;
        else if (stab_q == STAB_MAX)
            stab_d = stab_q;
        else
            stab_d = stab_q + 1'b1;

        // prev_q is the sample whose run length stab_q describes
        sel = anode_sel(prev_q[10:7]);
        dec = seg_decode(prev_q[6:0]);
        cap = (stab_q == STAB_HIT) && sel[2];

        shadow_d = shadow_q;
        sherr_d  = sherr_q;
        seen_d   = seen_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fd_d     = 1'b0;

        if (cap)
            tmo_d = '0;
        else if (tmo_q != TMO_HIT)
            tmo_d = tmo_q + 1'b1;
        else
            tmo_d = tmo_q;

        if (!cap && (tmo_q == TMO_HIT)) begin
            fv_d   = 1'b0;
            seen_d = 4'b0000;
        end

        if (seen_q == 4'b1111) begin
            bcd_d  = shadow_q;
            err_d  = sherr_q;
            fd_d   = 1'b1;
            fv_d   = 1'b1;
            seen_d = 4'b0000;
        end

        // a capture coinciding with completion starts the next frame's mask
        if (cap) begin
            seen_d[sel[1:0]] = 1'b1;
            if (dec[4]) begin
                shadow_d[{sel[1:0], 2'b00} +: 4] = dec[3:0];
                sherr_d[sel[1:0]] = 1'b0;
            end else begin
                sherr_d[sel[1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q   <= '1;
            prev_q   <= '1;
            stab_q   <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            sherr_q  <= '0;
            seen_q   <= '0;
            bcd_q    <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            samp_q   <= samp_d;
            prev_q   <= prev_d;
            stab_q   <= stab_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            sherr_q  <= sherr_d;
            seen_q   <= seen_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fd_q     <= fd_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign frame_done  = fd_q;

endmodule

// File: tb/tb_multiseg_capture.sv
// Directed plus randomized bench for multiseg_capture with a segment-level
// reference model (a pair held STABLE consecutive cycles captures once).
module tb_multiseg_capture;

    localparam int STB = 4;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  seg_anode;
    logic [6:0]  seg_cathode;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        frame_done;

    always #5 clk = ~clk;

    multiseg_capture #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg_anode(seg_anode), .seg_cathode(seg_cathode),
        .bcd_out(bcd_out), .digit_err(digit_err),
        .frame_valid(frame_valid), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int frames_pushed = 0;

    logic [6:0] ENC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // reference model state
    logic [15:0] m_shadow;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic [15:0] m_last_bcd;
    logic [3:0]  m_last_err;
    logic        m_fv;
    logic [10:0] m_prev;
    int          m_run;
    int          m_idle;
    logic [19:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int onehot_digit(input logic [3:0] an);
        for (int i = 0; i < 4; i++)
            if (an == (4'hF ^ (4'b0001 << i))) return i;
        return -1;
    endfunction

    function automatic int dec_digit(input logic [6:0] c);
        for (int i = 0; i < 10; i++)
            if (ENC[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_err = '0; m_seen = '0;
        m_last_bcd = '0; m_last_err = '0; m_fv = 1'b0;
        m_prev = {4'hF, 7'h7F}; m_run = 1000; m_idle = 0;
        exp_q.delete();
    endtask

    task automatic model_seg(input logic [3:0] an, input logic [6:0] ca, input int n);
        int old;
        int k;
        int d;
        bit captured;
        captured = 0;
        if ({an, ca} == m_prev) begin
            old = m_run;
            m_run = m_run + n;
        end else begin
            old = 0;
            m_run = n;
            m_prev = {an, ca};
        end
        k = onehot_digit(an);
        if (old < STB && m_run >= STB && k >= 0) begin
            captured = 1;
            d = dec_digit(ca);
            if (d < 0) m_err[k] = 1'b1;
            else begin
                m_shadow[4*k +: 4] = d[3:0];
                m_err[k] = 1'b0;
            end
            m_seen[k] = 1'b1;
            if (m_seen == 4'hF) begin
                exp_q.push_back({m_err, m_shadow});
                frames_pushed++;
                m_last_bcd = m_shadow;
                m_last_err = m_err;
                m_fv = 1'b1;
                m_seen = '0;
            end
        end
        if (captured) m_idle = m_run - STB;
        else m_idle = m_idle + n;
        if (m_idle > TMO + 10) begin
            m_seen = '0;
            m_fv = 1'b0;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] ca, input int n);
        model_seg(an, ca, n);
        seg_anode = an;
        seg_cathode = ca;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] val);
        for (int k = 0; k < 4; k++) begin
            drive(4'hF ^ (4'b0001 << k), ENC[val[4*k +: 4]], 6);
            drive(4'hF, 7'h7F, 2);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            logic [19:0] e;
            frames_seen++;
            chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_bcd", bcd_out, e[15:0]);
                chk("frame_err", digit_err, e[19:16]);
                chk("frame_valid_at_done", frame_valid, 1);
            end
        end
    end

    initial begin
        logic [3:0] an;
        logic [6:0] ca;
        int n;
        int r;
        bit force_cap;
        logic [15:0] val;

        model_reset();
        rst_n = 1'b0;
        seg_anode = 4'hF;
        seg_cathode = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", bcd_out, 0);
        chk("rst_err", digit_err, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 3);

        scan(16'h1234);
        scan(16'h1234);
        chk("loop_bcd", bcd_out, 16'h1234);
        chk("loop_err", digit_err, 0);
        chk("loop_fv", frame_valid, 1);

        for (int p = 0; p < 4; p++)
            for (int v = 0; v < 10; v++) begin
                val = 16'(v) << (4 * p);
                scan(val);
                chk("sweep_bcd", bcd_out, val);
                chk("sweep_err", digit_err, 0);
            end

        scan(16'h0005);
        drive(4'b1110, 7'h7F, 20);
        drive(4'b1101, 7'h40, 8);
        drive(4'b1011, 7'h40, 8);
        drive(4'b0111, 7'h40, 8);
        drive(4'hF, 7'h7F, 4);
        chk("blank_bcd", bcd_out, 16'h0005);
        chk("blank_err", digit_err, 4'b0001);

        drive(4'b1101, 7'h79, 3);
        drive(4'hF, 7'h7F, 6);
        drive(4'b1110, ENC[7], 6);
        drive(4'b1011, ENC[8], 6);
        drive(4'b0111, ENC[9], 6);
        drive(4'hF, 7'h7F, 6);
        chk("glitch_no_frame", frames_seen, frames_pushed);
        chk("glitch_hold_bcd", bcd_out, 16'h0005);
        drive(4'b1101, 7'h79, 4);
        drive(4'hF, 7'h7F, 6);
        chk("glitch_cap_bcd", bcd_out, 16'h9817);
        chk("glitch_cap_err", digit_err, 0);

        drive(4'b1100, ENC[3], 100);
        drive(4'b1111, ENC[4], 100);
        chk("ghost_no_frame", frames_seen, frames_pushed);
        chk("ghost_err", digit_err, m_last_err);
        chk("ghost_fv", frame_valid, m_fv);
        drive(4'hF, 7'h7F, TMO + 40);
        chk("tmo_fv", frame_valid, m_fv);
        chk("tmo_bcd", bcd_out, m_last_bcd);
        chk("tmo_err", digit_err, m_last_err);

        for (int i = 0; i < 300; i++) begin
            force_cap = (m_idle > 100);
            r = $urandom_range(0, 9);
            if (r < 7 || force_cap)
                an = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
            else if (r == 7)
                an = 4'hF;
            else
                an = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) ca = ENC[$urandom_range(0, 9)];
            else ca = 7'($urandom_range(0, 127));
            n = force_cap ? $urandom_range(STB, 10) : $urandom_range(1, 10);
            drive(an, ca, n);
        end
        drive(4'hF, 7'h7F, 10);
        chk("rand_bcd", bcd_out, m_last_bcd);
        chk("rand_err", digit_err, m_last_err);
        chk("rand_fv", frame_valid, m_fv);

        drive(4'b1110, ENC[1], 6);
        drive(4'b1101, ENC[2], 6);
        drive(4'hF, 7'h7F, 2);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_bcd", bcd_out, 0);
        chk("mid_rst_err", digit_err, 0);
        chk("mid_rst_fv", frame_valid, 0);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 3);
        drive(4'b1110, ENC[6], 6);
        drive(4'b1101, ENC[7], 6);
        drive(4'b1011, ENC[8], 6);
        drive(4'hF, 7'h7F, 6);
        chk("post_rst_no_frame", frames_seen, frames_pushed);
        chk("post_rst_bcd_hold", bcd_out, 0);
        drive(4'b0111, ENC[3], 6);
        drive(4'hF, 7'h7F, 6);
        chk("post_rst_bcd", bcd_out, 16'h3876);
        chk("post_rst_fv", frame_valid, 1);

        drive(4'hF, 7'h7F, 10);
        chk("frame_count", frames_seen, frames_pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
